// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared constants and types for the SRAM bank initiator
// Purpose: geometry of the attached bank array, request record and bank index type.
// Ports: none (package).
package sram_bank_pkg;

  localparam int NBANKS    = 4;                    // attached banks, power of 2, >= 2
  localparam int AW        = 9;                    // row address width per bank
  localparam int DW        = 32;                   // data width
  localparam int BW        = $clog2(NBANKS);       // bank index width
  localparam int RSP_DEPTH = 2;                    // response entries == read credits
  localparam int CW        = $clog2(RSP_DEPTH + 1);// width of the outstanding-read counter

  typedef logic [BW-1:0] bank_idx_t;

  typedef struct packed {
    logic               we;
    logic [BW+AW-1:0]   addr;   // {bank index, row}
    logic [DW-1:0]      wdata;
  } bank_req_t;

  function automatic logic [NBANKS-1:0] bank_onehot(input bank_idx_t idx);
    bank_onehot      = '0;
    bank_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - small synchronous FIFO holding read responses
// Purpose: DEPTH x WIDTH in-order buffer with push/pop and full/empty flags.
// Ports: clk, reset (async, active-high); i_push/i_wdata write side;
//        i_pop/o_rdata read side (o_rdata shows the oldest entry); o_full, o_empty.
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [FW-1:0]    r_count;

  // Pointers wrap explicitly so non-power-of-2 depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + FW'(1);
        2'b01:   r_count <= r_count - FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FW'(DEPTH));
  assign o_empty = (r_count == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(i_push && o_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(i_pop && o_empty));

endmodule

// File: rtl/sram_bank_initiator.sv
// rtl/sram_bank_initiator.sv - valid/ready front end for an array of synchronous SRAM banks
// Purpose: accepts read/write requests, drives registered bank strobes, captures the
//          addressed bank's registered dataout and returns read data in order.
// Ports: clk, reset (async, active-high);
//        req_valid/req_ready/req_we/req_addr/req_wdata - request channel ({bank, row});
//        rsp_valid/rsp_ready/rsp_rdata - in-order read response channel;
//        bank_sel/bank_read/bank_write/bank_addr/bank_wd - shared bank strobes;
//        bank_dataout - concatenated bank outputs, bank i at [i*DW +: DW].
module sram_bank_initiator
  import sram_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BW+AW-1:0]     req_addr,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_rdata,
  output logic [NBANKS-1:0]    bank_sel,
  output logic                 bank_read,
  output logic                 bank_write,
  output logic [AW-1:0]        bank_addr,
  output logic [DW-1:0]        bank_wd,
  input  logic [NBANKS*DW-1:0] bank_dataout
);

  bank_req_t        w_req;
  bank_idx_t        w_req_idx;
  logic [AW-1:0]    w_req_row;
  logic             w_accept;
  logic             w_rd_accept;
  logic             w_rsp_pop;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [DW-1:0]    w_cap_data;

  logic [NBANKS-1:0] r_bank_sel;
  logic              r_bank_read;
  logic              r_bank_write;
  logic [AW-1:0]     r_bank_addr;
  logic [DW-1:0]     r_bank_wd;
  bank_idx_t         r_iss_idx;     // bank of the access currently on the strobes
  logic              r_rd_pipe;     // a read was sampled by the bank at the last edge
  bank_idx_t         r_rd_idx;      // which bank's dataout to capture
  logic [CW-1:0]     r_rd_cnt;      // accepted reads not yet handed to the client

  assign w_req       = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign w_req_idx   = w_req.addr[BW+AW-1:AW];
  assign w_req_row   = w_req.addr[AW-1:0];

  // Credit-based: ready depends only on registered state, never on req_valid.
  assign req_ready   = (r_rd_cnt < CW'(RSP_DEPTH));
  assign w_accept    = req_valid & req_ready;
  assign w_rd_accept = w_accept & ~w_req.we;
  assign w_rsp_pop   = rsp_valid & rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_sel   <= '0;
      r_bank_read  <= 1'b0;
      r_bank_write <= 1'b0;
      r_bank_addr  <= '0;
      r_bank_wd    <= '0;
      r_iss_idx    <= '0;
      r_rd_pipe    <= 1'b0;
      r_rd_idx     <= '0;
      r_rd_cnt     <= '0;
    end else begin
      // Strobes are single-cycle; address and write data hold between accesses.
      r_bank_sel   <= w_accept ? bank_onehot(w_req_idx) : '0;
      r_bank_read  <= w_accept & ~w_req.we;
      r_bank_write <= w_accept &  w_req.we;
      if (w_accept) begin
        r_bank_addr <= w_req_row;
        r_bank_wd   <= w_req.wdata;
        r_iss_idx   <= w_req_idx;
      end

      // The bank registers dataout at the edge it sees bank_read; capture one edge later.
      r_rd_pipe <= r_bank_read;
      r_rd_idx  <= r_iss_idx;

      case ({w_rd_accept, w_rsp_pop})
        2'b10:   r_rd_cnt <= r_rd_cnt + CW'(1);
        2'b01:   r_rd_cnt <= r_rd_cnt - CW'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  assign w_cap_data = bank_dataout[r_rd_idx*DW +: DW];

  // Credits guarantee room, so the push side never needs back-pressure.
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DW)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_rd_pipe),
    .i_wdata (w_cap_data),
    .i_pop   (w_rsp_pop),
    .o_rdata (rsp_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign rsp_valid  = ~w_fifo_empty;
  assign bank_sel   = r_bank_sel;
  assign bank_read  = r_bank_read;
  assign bank_write = r_bank_write;
  assign bank_addr  = r_bank_addr;
  assign bank_wd    = r_bank_wd;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    (bank_read || bank_write) |-> ($onehot(bank_sel) && !(bank_read && bank_write)));
  a_capture_room: assert property (@(posedge clk) disable iff (reset)
    !(r_rd_pipe && w_fifo_full));

endmodule
